// File: rtl/ln_mean_accum.sv
// Streaming FP vector accumulator feeding fp_div_pipe: sums vec_len elements and issues sum / N.
// Optional macro LN_ACC_SQ_EN adds a sum-of-squares path and a second request for E[x^2].
module ln_mean_accum #(
  parameter int sig_width = 23,
  parameter int exp_width = 8,
  parameter int ieee_compliance = 0,
  parameter int vec_len = 64,
  parameter logic [sig_width+exp_width:0] n_fp = 32'h42800000,
  localparam int W = sig_width + exp_width + 1,
  localparam int CW = $clog2(vec_len)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         flush,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic         ab_valid,
  output logic         ab_is_sq,
  output logic         busy
);

  localparam int SW = sig_width;
  localparam int EW = exp_width;
  localparam logic [EW-1:0] EMAX = '1;
  localparam logic signed [EW+1:0] E_ONE = 1;
  localparam logic signed [EW+1:0] E_ZERO = 0;
  localparam logic signed [EW+1:0] E_INF = {2'b00, EMAX};
  // Invalid operations (inf - inf, 0 * inf): quiet NaN in IEEE mode, infinity otherwise.
  localparam logic [W-1:0] NAN_VAL = (ieee_compliance != 0) ?
    {1'b0, EMAX, 1'b1, {(SW-1){1'b0}}} : {1'b0, EMAX, {SW{1'b0}}};

  // Round-to-nearest-even on a normalised significand with guard and sticky bits.
  function automatic logic [W-1:0] fp_pack(input logic s, input logic signed [EW+1:0] e_in,
                                           input logic [SW:0] m, input logic g, input logic st);
    logic [SW+1:0] mr;
    logic signed [EW+1:0] e;
    logic inc;
    e = e_in;
    inc = g & (st | m[0]);
    mr = {1'b0, m} + (SW+2)'(inc);
    if (mr[SW+1]) e = e + E_ONE;
    if (e <= E_ZERO) return {s, {(W-1){1'b0}}};
    if (e >= E_INF) return {s, EMAX, {SW{1'b0}}};
    return {s, e[EW-1:0], mr[SW-1:0]};
  endfunction

  function automatic logic [W-1:0] fp_add(input logic [W-1:0] x, input logic [W-1:0] y);
    logic sx, sy, sl, ss;
    logic [EW-1:0] ex, ey, el, es;
    logic [SW-1:0] fx, fy;
    logic [SW+4:0] al, as_, sum;
    logic signed [EW+1:0] e;
    logic sticky;
    int d;
    {sx, ex, fx} = x;
    {sy, ey, fy} = y;
    if (ex == EMAX || ey == EMAX) begin
      if (ex == EMAX && fx != '0) return x;
      if (ey == EMAX && fy != '0) return y;
      if (ex == EMAX && ey == EMAX && sx != sy) return NAN_VAL;
      return (ex == EMAX) ? x : y;
    end
    // Denormals are treated as zero; -0 + -0 keeps its sign.
    if (ex == '0 && ey == '0) return {sx & sy, {(W-1){1'b0}}};
    if (ex == '0) return y;
    if (ey == '0) return x;
    if ({ex, fx} >= {ey, fy}) begin
      sl = sx; el = ex; al = {2'b01, fx, 3'b000};
      ss = sy; es = ey; as_ = {2'b01, fy, 3'b000};
    end else begin
      sl = sy; el = ey; al = {2'b01, fy, 3'b000};
      ss = sx; es = ex; as_ = {2'b01, fx, 3'b000};
    end
    d = int'(el) - int'(es);
    sticky = 1'b0;
    for (int i = 0; i < SW + 5; i++) begin
      if (i < d) sticky = sticky | as_[i];
    end
    as_ = (d >= SW + 5) ? '0 : (as_ >> d);
    as_[0] = as_[0] | sticky;
    sum = (sl == ss) ? (al + as_) : (al - as_);
    if (sum == '0) return '0;
    e = signed'({2'b00, el});
    if (sum[SW+4]) begin
      sum = {1'b0, sum[SW+4:2], sum[1] | sum[0]};
      e = e + E_ONE;
    end else begin
      for (int i = 0; i < SW + 3; i++) begin
        if (!sum[SW+3]) begin
          sum = sum << 1;
          e = e - E_ONE;
        end
      end
    end
    return fp_pack(sl, e, sum[SW+3:3], sum[2], sum[1] | sum[0]);
  endfunction

`ifdef LN_ACC_SQ_EN
  localparam logic signed [EW+1:0] E_BIAS = (1 <<< (EW - 1)) - 1;

  function automatic logic [W-1:0] fp_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic sx, sy, s;
    logic [EW-1:0] ex, ey;
    logic [SW-1:0] fx, fy;
    logic [2*SW+1:0] p;
    logic signed [EW+1:0] e;
    {sx, ex, fx} = x;
    {sy, ey, fy} = y;
    s = sx ^ sy;
    if (ex == EMAX && fx != '0) return x;
    if (ey == EMAX && fy != '0) return y;
    if (ex == EMAX || ey == EMAX) begin
      if (ex == '0 || ey == '0) return NAN_VAL;
      return {s, EMAX, {SW{1'b0}}};
    end
    if (ex == '0 || ey == '0) return {s, {(W-1){1'b0}}};
    p = {1'b1, fx} * {1'b1, fy};
    e = signed'({2'b00, ex}) + signed'({2'b00, ey}) - E_BIAS;
    if (p[2*SW+1])
      return fp_pack(s, e + E_ONE, p[2*SW+1:SW+1], p[SW], |p[SW-1:0]);
    return fp_pack(s, e, p[2*SW:SW], p[SW-1], |p[SW-2:0]);
  endfunction
`endif

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
`ifdef LN_ACC_SQ_EN
    ISSUE,
    ISSUE_SQ
`else
    ISSUE
`endif
  } state_t;

  state_t state, state_nxt;
  logic [W-1:0] acc, sum_nxt, a_q, b_q;
  logic [CW-1:0] cnt;
  logic ab_valid_q;
  logic accept, last;

  assign in_ready = (state == IDLE) || (state == ACCUM);
  assign busy     = (state != IDLE);
  assign accept   = in_valid & in_ready;
  assign last     = (state == ACCUM) && (cnt == CW'(vec_len - 1));
  assign sum_nxt  = fp_add(acc, in_data);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (accept) state_nxt = ACCUM;
      ACCUM: if (accept && last) state_nxt = ISSUE;
`ifdef LN_ACC_SQ_EN
      ISSUE:    state_nxt = ISSUE_SQ;
      ISSUE_SQ: state_nxt = IDLE;
`else
      ISSUE:    state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

`ifdef LN_ACC_SQ_EN
  logic [W-1:0] acc_sq, sq, sq_sum;
  logic ab_is_sq_q;

  assign sq     = fp_mul(in_data, in_data);
  assign sq_sum = fp_add(acc_sq, sq);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      acc_sq     <= '0;
      cnt        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      ab_valid_q <= 1'b0;
      ab_is_sq_q <= 1'b0;
    end else begin
      ab_valid_q <= 1'b0;
      if (flush) begin
        acc    <= '0;
        acc_sq <= '0;
        cnt    <= '0;
      end else begin
        case (state)
          IDLE: if (accept) begin
            acc    <= in_data;
            acc_sq <= sq;
            cnt    <= CW'(1);
          end
          ACCUM: if (accept) begin
            acc    <= sum_nxt;
            acc_sq <= sq_sum;
            if (last) begin
              a_q        <= sum_nxt;
              b_q        <= n_fp;
              ab_valid_q <= 1'b1;
              ab_is_sq_q <= 1'b0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          ISSUE: begin
            a_q        <= acc_sq;
            b_q        <= n_fp;
            ab_valid_q <= 1'b1;
            ab_is_sq_q <= 1'b1;
          end
          default: begin
            acc    <= '0;
            acc_sq <= '0;
            cnt    <= '0;
          end
        endcase
      end
    end
  end

  assign ab_is_sq = ab_is_sq_q;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      cnt        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      ab_valid_q <= 1'b0;
    end else begin
      ab_valid_q <= 1'b0;
      if (flush) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        case (state)
          IDLE: if (accept) begin
            acc <= in_data;
            cnt <= CW'(1);
          end
          ACCUM: if (accept) begin
            acc <= sum_nxt;
            if (last) begin
              a_q        <= sum_nxt;
              b_q        <= n_fp;
              ab_valid_q <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            acc <= '0;
            cnt <= '0;
          end
        endcase
      end
    end
  end

  assign ab_is_sq = 1'b0;
`endif

  assign a        = a_q;
  assign b        = b_q;
  assign ab_valid = ab_valid_q;

endmodule
